muldiv_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource used by mult, multu, div, divu, madd, maddu, msub, msubu, mul, mthi, mtlo, mfhi and mflo.
- Sits beside the EX stage and accepts one operation at a time from the decoder/EX pipeline register.
- Runs an iterative shift-add multiplier or restoring divider over WIDTH cycles and owns the HI/LO registers.
- Drives a pipeline stall for hazards against in-flight operations.

---
 rtl/muldiv_pkg.sv | 39 +++
 rtl/muldiv_iter_core.sv | 79 +++++++
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and op-class helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_MULT  = 4'h1;
   localparam logic [3:0] OP_MULTU = 4'h2;
   localparam logic [3:0] OP_DIV   = 4'h3;
   localparam logic [3:0] OP_DIVU  = 4'h4;
   localparam logic [3:0] OP_MADD  = 4'h5;
   localparam logic [3:0] OP_MADDU = 4'h6;
   localparam logic [3:0] OP_MSUB  = 4'h7;
   localparam logic [3:0] OP_MSUBU = 4'h8;
   localparam logic [3:0] OP_MUL   = 4'h9;
   localparam logic [3:0] OP_MTHI  = 4'hA;
   localparam logic [3:0] OP_MTLO  = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   function automatic logic is_signed(input logic [3:0] o);
      return o inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB, OP_MUL};
   endfunction

   function automatic logic is_mul(input logic [3:0] o);
      return o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL};
   endfunction

   function automatic logic is_acc(input logic [3:0] o);
      return o inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
   endfunction

   function automatic logic is_div(input logic [3:0] o);
      return o inside {OP_DIV, OP_DIVU};
   endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative datapath: one shift-add multiply or restoring-divide step per cycle on magnitudes.
// MULDIV_FAST_MUL_EN: multiplies load a full array product at start and report last immediately.
module muldiv_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               step,
   input  logic               div_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last,
   output logic [2*WIDTH-1:0] acc
);
`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int CW = $clog2(WIDTH);

   // p holds the running product, or {remainder, quotient/dividend} when dividing
   logic [2*WIDTH-1:0] p_q, p_d, m_q, m_d;
   logic [WIDTH-1:0]   b_q, b_d, rem_n;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               div_q, div_d;
   logic [WIDTH:0]     r_sh, diff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= '0;
         m_q   <= '0;
         b_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         p_q   <= p_d;
         m_q   <= m_d;
         b_q   <= b_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   always_comb begin
      p_d   = p_q;
      m_d   = m_q;
      b_d   = b_q;
      cnt_d = cnt_q;
      div_d = div_q;
      r_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
      diff  = r_sh - {1'b0, b_q};
      rem_n = diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      if (start) begin
         div_d = div_mode;
         b_d   = b;
         cnt_d = CW'(WIDTH - 1);
         m_d   = {{WIDTH{1'b0}}, a};
         p_d   = div_mode ? {{WIDTH{1'b0}}, a} : '0;
         if (FAST && !div_mode)
            p_d = m_d * {{WIDTH{1'b0}}, b};
      end else if (step && !(FAST && !div_q)) begin
         cnt_d = cnt_q - CW'(1);
         if (div_q) begin
            p_d = {rem_n, p_q[WIDTH-2:0], ~diff[WIDTH]};
         end else begin
            if (b_q[0])
               p_d = p_q + m_q;
            m_d = m_q << 1;
            b_d = b_q >> 1;
         end
      end
   end

   assign last = (FAST && !div_q) || (cnt_q == '0);
   assign acc  = p_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: FSM, hazard stall, sign fix-up and HI/LO ownership.
// MULDIV_FAST_MUL_EN (in muldiv_iter_core) shortens multiply-class CALC to one cycle.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             hilo_rd,
   input  logic             flush,
   output logic             busy_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   state_e             state_q, state_d;
   logic [3:0]         cur_op_q, cur_op_d;
   logic               nres_q, nres_d, nrem_q, nrem_d, dz_q, dz_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d, hi_q, hi_d, lo_q, lo_d;
   logic               accept, go_calc, sgn, core_last;
   logic [WIDTH-1:0]   a_mag, b_mag, quot_s, rem_s;
   logic [2*WIDTH-1:0] core_acc, prod_s, hilo;

   assign accept  = op_valid & ~flush & (state_q == ST_IDLE) & (op != OP_NOP) & (op <= OP_MTLO);
   assign go_calc = accept & (is_mul(op) | is_div(op));
   assign sgn     = is_signed(op);
   assign a_mag   = (sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign b_mag   = (sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;

   muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (go_calc),
      .step     (state_q == ST_CALC),
      .div_mode (is_div(op)),
      .a        (a_mag),
      .b        (b_mag),
      .last     (core_last),
      .acc      (core_acc)
   );

   // Sign correction applied to the magnitude results
   assign prod_s = nres_q ? -core_acc : core_acc;
   assign quot_s = nres_q ? -core_acc[WIDTH-1:0] : core_acc[WIDTH-1:0];
   assign rem_s  = nrem_q ? -core_acc[2*WIDTH-1:WIDTH] : core_acc[2*WIDTH-1:WIDTH];
   assign hilo   = {hi_q, lo_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (go_calc) state_d = ST_CALC;
         ST_CALC: if (flush) state_d = ST_IDLE;
                  else if (core_last) state_d = ST_FIN;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_o  = (state_q != ST_IDLE);
      done_o  = (state_q == ST_FIN) & ~flush;
      stall_o = (busy_o & (op_valid | hilo_rd)) | (accept & (op == OP_MUL))
              | ((state_q == ST_CALC) & (cur_op_q == OP_MUL));
      res_o   = (done_o & (cur_op_q == OP_MUL)) ? prod_s[WIDTH-1:0] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_op_q <= OP_NOP;
         nres_q   <= 1'b0;
         nrem_q   <= 1'b0;
         dz_q     <= 1'b0;
         dvd_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         cur_op_q <= cur_op_d;
         nres_q   <= nres_d;
         nrem_q   <= nrem_d;
         dz_q     <= dz_d;
         dvd_q    <= dvd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   always_comb begin
      cur_op_d = cur_op_q;
      nres_d   = nres_q;
      nrem_d   = nrem_q;
      dz_d     = dz_q;
      dvd_d    = dvd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      if (accept) begin
         cur_op_d = op;
         nres_d   = sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
         nrem_d   = sgn & rs_val[WIDTH-1];
         dz_d     = (rt_val == '0);
         dvd_d    = rs_val;
         if (op == OP_MTHI) hi_d = rs_val;
         if (op == OP_MTLO) lo_d = rs_val;
      end
      // done_o already folds in flush, so an aborted FIN commits nothing
      if (done_o) begin
         if (is_div(cur_op_q)) begin
            lo_d = dz_q ? '1 : quot_s;
            hi_d = dz_q ? dvd_q : rem_s;
         end else if (is_acc(cur_op_q)) begin
            if (cur_op_q inside {OP_MSUB, OP_MSUBU}) {hi_d, lo_d} = hilo - prod_s;
            else                                     {hi_d, lo_d} = hilo + prod_s;
         end else if (cur_op_q != OP_MUL) begin
            {hi_d, lo_d} = prod_s;
         end
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl with hand-computed expected HI/LO/res values.
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MLAT = 1;
`else
   localparam int MLAT = W;
`endif
   localparam int DLAT = W;

   logic         clk = 1'b0, rst_n = 1'b1, op_valid = 1'b0, hilo_rd = 1'b0, flush = 1'b0;
   logic [3:0]   op = OP_NOP;
   logic [W-1:0] rs_val = '0, rt_val = '0;
   logic         busy_o, stall_o, done_o;
   logic [W-1:0] res_o, hi_o, lo_o;
   int           checks = 0, errors = 0;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .hilo_rd(hilo_rd), .flush(flush), .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
      .res_o(res_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [3:0]   o;
      logic [W-1:0] a, b;
      int           lat;
      logic [W-1:0] hi, lo;
   } vec_t;

   // Presents one op for a single accept edge; returns 1 time unit after that edge
   task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk); #1;
      op_valid = 1'b0; op = OP_NOP;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #3;
      checks++;
      if ({busy_o, stall_o, done_o} !== 3'b000 || res_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
         errors++;
         $display("FAIL reset: busy=%b stall=%b done=%b res=%h hi=%h lo=%h, want all 0",
                  busy_o, stall_o, done_o, res_o, hi_o, lo_o);
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_arith();
      vec_t v[10];
      v[0] = '{"mult",     OP_MULT,  32'hFFFFFFFE, 32'd3,        MLAT, 32'hFFFFFFFF, 32'hFFFFFFFA};
      v[1] = '{"multu",    OP_MULTU, 32'hFFFFFFFE, 32'd3,        MLAT, 32'h00000002, 32'hFFFFFFFA};
      v[2] = '{"div",      OP_DIV,   32'hFFFFFFF9, 32'd2,        DLAT, 32'hFFFFFFFF, 32'hFFFFFFFD};
      v[3] = '{"divu_z",   OP_DIVU,  32'd7,        32'd0,        DLAT, 32'h00000007, 32'hFFFFFFFF};
      v[4] = '{"div_ovf",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, DLAT, 32'h00000000, 32'h80000000};
      v[5] = '{"div_z",    OP_DIV,   32'hFFFFFFF9, 32'd0,        DLAT, 32'hFFFFFFF9, 32'hFFFFFFFF};
      v[6] = '{"mthi0",    OP_MTHI,  32'd0,        32'd0,        0,    32'h00000000, 32'hFFFFFFFF};
      v[7] = '{"mtlo5",    OP_MTLO,  32'd5,        32'd0,        0,    32'h00000000, 32'h00000005};
      v[8] = '{"madd",     OP_MADD,  32'd2,        32'd3,        MLAT, 32'h00000000, 32'h0000000B};
      v[9] = '{"msubu",    OP_MSUBU, 32'd4,        32'd4,        MLAT, 32'hFFFFFFFF, 32'hFFFFFFFB};
      for (int i = 0; i < 10; i++) begin
         issue(v[i].o, v[i].a, v[i].b);
         if (v[i].lat > 0) begin
            checks++;
            if (busy_o !== 1'b1) begin
               errors++; $display("FAIL %s busy after accept: got %b want 1", v[i].name, busy_o);
            end
            repeat (v[i].lat) @(posedge clk);
            #1;
            checks++;
            if (done_o !== 1'b1) begin
               errors++; $display("FAIL %s done in FIN: got %b want 1", v[i].name, done_o);
            end
            @(posedge clk); #1;
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b0) begin
               errors++; $display("FAIL %s idle after FIN: done=%b busy=%b want 0 0", v[i].name, done_o, busy_o);
            end
         end else begin
            checks++;
            if (busy_o !== 1'b0) begin
               errors++; $display("FAIL %s busy: got %b want 0", v[i].name, busy_o);
            end
         end
         checks++;
         if (hi_o !== v[i].hi || lo_o !== v[i].lo) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h want %h_%h", v[i].name, hi_o, lo_o, v[i].hi, v[i].lo);
         end
      end
   endtask

   task automatic test_mthi();
      issue(OP_MTHI, 32'h1234, 32'd0);
      checks++;
      if (hi_o !== 32'h1234 || lo_o !== 32'hFFFFFFFB || busy_o !== 1'b0) begin
         errors++; $display("FAIL mthi: hi=%h lo=%h busy=%b want 1234 fffffffb 0", hi_o, lo_o, busy_o);
      end
   endtask

   task automatic test_mul();
      logic [W-1:0] a[2], exp_res[2];
      int n;
      a[0] = 32'd6;          exp_res[0] = 32'd42;
      a[1] = 32'hFFFFFFFA;   exp_res[1] = 32'hFFFFFFD6;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         op_valid = 1'b1; op = OP_MUL; rs_val = a[i]; rt_val = 32'd7;
         #1;
         checks++;
         if (stall_o !== 1'b1) begin
            errors++; $display("FAIL mul%0d accept stall: got %b want 1", i, stall_o);
         end
         @(posedge clk); #1;
         op_valid = 1'b0; op = OP_NOP;
         n = 0;
         for (int c = 0; c < MLAT; c++) begin
            if (stall_o === 1'b1) n++;
            @(posedge clk); #1;
         end
         checks++;
         if (n != MLAT) begin
            errors++; $display("FAIL mul%0d calc stall cycles: got %0d want %0d", i, n, MLAT);
         end
         checks++;
         if (done_o !== 1'b1 || res_o !== exp_res[i] || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL mul%0d fin: done=%b res=%h stall=%b want 1 %h 0", i, done_o, res_o, stall_o, exp_res[i]);
         end
         @(posedge clk); #1;
         checks++;
         if (hi_o !== 32'h1234 || lo_o !== 32'hFFFFFFFB || res_o !== '0) begin
            errors++; $display("FAIL mul%0d hilo kept: hi=%h lo=%h res=%h want 1234 fffffffb 0", i, hi_o, lo_o, res_o);
         end
      end
   endtask

   task automatic test_hazard();
      int n = 0;
      issue(OP_MULT, 32'd3, 32'd4);
      hilo_rd = 1'b1;
      while (stall_o === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      checks++;
      if (n != MLAT + 1) begin
         errors++; $display("FAIL hazard stall cycles: got %0d want %0d", n, MLAT + 1);
      end
      checks++;
      if (lo_o !== 32'd12 || hi_o !== 32'd0) begin
         errors++; $display("FAIL hazard mflo: hi=%h lo=%h want 0 c", hi_o, lo_o);
      end
      hilo_rd = 1'b0;
   endtask

   task automatic test_flush();
      int n = 0;
      issue(OP_DIV, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      #1;
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL flush calc: done=%b busy=%b want 0 1", done_o, busy_o);
      end
      @(posedge clk); #1 flush = 1'b0;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL flush idle: busy=%b want 0", busy_o);
      end
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done_o !== 1'b0) n++;
      end
      checks++;
      if (n != 0 || hi_o !== 32'd0 || lo_o !== 32'd12) begin
         errors++; $display("FAIL flush no commit: done_pulses=%0d hi=%h lo=%h want 0 0 c", n, hi_o, lo_o);
      end
   endtask

   task automatic test_flush_idle();
      @(negedge clk);
      op_valid = 1'b1; op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; op = 4'hD;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++; $display("FAIL flush with op in idle: busy=%b want 0", busy_o);
      end
      @(posedge clk); #1;
      op_valid = 1'b0; op = OP_NOP;
      checks++;
      if (busy_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd12) begin
         errors++; $display("FAIL op 0xD as nop: busy=%b hi=%h lo=%h want 0 0 c", busy_o, hi_o, lo_o);
      end
   endtask

   task automatic test_reset_mid();
      issue(OP_MULTU, 32'd5, 32'd5);
      repeat (5) @(posedge clk);
      hilo_rd = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_o, stall_o, done_o} !== 3'b000 || res_o !== '0 || hi_o !== '0 || lo_o !== '0) begin
         errors++;
         $display("FAIL reset mid-calc: busy=%b stall=%b done=%b res=%h hi=%h lo=%h want all 0",
                  busy_o, stall_o, done_o, res_o, hi_o, lo_o);
      end
      hilo_rd = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b0 || lo_o !== '0) begin
         errors++; $display("FAIL post-reset idle: busy=%b lo=%h want 0 0", busy_o, lo_o);
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_mthi();
      test_mul();
      test_hazard();
      test_flush();
      test_flush_idle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
